// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with multi-cycle shift-add multiply and restoring divide.
// Define ALU_DIV_EN to build the divider; without it op 9 decodes as an illegal op.
`timescale 1ns/1ps
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] HI,
    output logic             CF,
    output logic             OF,
    output logic             ZERO,
    output logic             busy,
    output logic             done,
    output logic [6:0]       LED
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_NOT = 4'd2, OP_AND = 4'd3,
                           OP_OR  = 4'd4, OP_XOR = 4'd5, OP_GT  = 4'd6, OP_EQ  = 4'd7,
                           OP_MUL = 4'd8, OP_DIV = 4'd9;

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] f_q, hi_q;
    logic             cf_q, of_q, zero_q, busy_q, done_q, is_div_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] wh_q, wl_q, opnd_q;

    logic [WIDTH:0]   add_w, sub_w, mul_sum;
    logic [WIDTH-1:0] sc_f, sc_hi, step_h, step_l;
    logic             sc_cf, sc_of, go_mul, go_div;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Single-cycle results come straight from the operand ports at the capturing edge
    always_comb begin
        add_w  = {1'b0, A} + {1'b0, B};
        sub_w  = {1'b0, A} - {1'b0, B};
        sc_f   = '0;
        sc_hi  = '0;
        sc_cf  = 1'b0;
        sc_of  = 1'b0;
        go_mul = 1'b0;
        go_div = 1'b0;
        case (op)
            OP_ADD: begin
                sc_f  = add_w[WIDTH-1:0];
                sc_cf = add_w[WIDTH];
                sc_of = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_f  = sub_w[WIDTH-1:0];
                sc_cf = sub_w[WIDTH];
                sc_of = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_NOT: sc_f = ~A;
            OP_AND: sc_f = A & B;
            OP_OR:  sc_f = A | B;
            OP_XOR: sc_f = A ^ B;
            OP_GT:  sc_f = {{(WIDTH-1){1'b0}}, ($signed(A) > $signed(B))};
            OP_EQ:  sc_f = {{(WIDTH-1){1'b0}}, (A == B)};
            OP_MUL: go_mul = 1'b1;
`ifdef ALU_DIV_EN
            OP_DIV: begin
                if (B == '0) begin
                    sc_f  = '1;
                    sc_hi = A;
                    sc_of = 1'b1;
                end else begin
                    go_div = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

`ifdef ALU_DIV_EN
    logic [WIDTH:0] div_in, div_trial;
`endif

    // wh/wl hold {HI,F} for multiply and {remainder,quotient} for divide
    always_comb begin
        mul_sum = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        step_h  = mul_sum[WIDTH:1];
        step_l  = {mul_sum[0], wl_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_in    = {wh_q, wl_q[WIDTH-1]};
        div_trial = div_in - {1'b0, opnd_q};
        if (is_div_q) begin
            step_h = div_trial[WIDTH] ? div_in[WIDTH-1:0] : div_trial[WIDTH-1:0];
            step_l = {wl_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE) begin
            wh_q   <= '0;
            wl_q   <= go_div ? A : B;
            opnd_q <= go_div ? B : A;
        end else begin
            wh_q   <= step_h;
            wl_q   <= step_l;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            f_q      <= '0;
            hi_q     <= '0;
            cf_q     <= 1'b0;
            of_q     <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (go_mul || go_div) begin
                            state_q  <= CALC;
                            busy_q   <= 1'b1;
                            is_div_q <= go_div;
                            cnt_q    <= CW'(WIDTH);
                        end else begin
                            f_q    <= sc_f;
                            hi_q   <= sc_hi;
                            cf_q   <= sc_cf;
                            of_q   <= sc_of;
                            zero_q <= (sc_f == '0);
                            done_q <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        f_q     <= step_l;
                        hi_q    <= step_h;
                        cf_q    <= !is_div_q && (step_h != '0);
                        of_q    <= !is_div_q && (step_h != '0);
                        zero_q  <= (step_l == '0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign F    = f_q;
    assign HI   = hi_q;
    assign CF   = cf_q;
    assign OF   = of_q;
    assign ZERO = zero_q;
    assign busy = busy_q;
    assign done = done_q;
    assign LED  = seg7(f_q[3:0]);
endmodule
